serial_frame_decoder: RTL and testbench
=======================================

# serial_frame_decoder

Parametrised byte-stream frame decoder. Second generation of the UART message receiver: a configurable sync preamble, a type byte selecting one of NUM_TYPES payload lengths, and an XOR checksum trailer. It also detects inter-byte timeouts and reports typed errors. It sits between the UART RX core and the particle/map loaders, forwarding payload bytes tagged with their message type.

## Interface
- SYNC_LEN, 2: preamble length in bytes, ≥1.
- SYNC_PATTERN, 16'hA55A: preamble, SYNC_LEN*8 bits; first byte received is in the MSBs.
- NUM_TYPES, 2: number of message types, ≥1.
- TYPE_CODES, {8'h02,8'h01}: packed NUM_TYPES*8; the code for type i is at [8i+7:8i].
- PAYLOAD_LENS, {16'd5,16'd3}: packed NUM_TYPES*16; the payload byte count for type i is at [16i+15:16i]. Each count is ≥1.
- TIMEOUT_CYCLES, 100000: maximum idle clocks between bytes inside a frame. 0 disables the timeout.
- clk  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte, valid while rx_data_ready is high.
- rx_data_ready  in  1  one-cycle strobe per received byte.
- msg_out  out  8  payload byte.
- msg_type  out  max(1,$clog2(NUM_TYPES))  index i of the matched type. Held for the whole frame.
- msg_valid  out  1  one-cycle pulse per payload byte.
- msg_first / msg_last  out  1 each  qualify the first and last payload byte. Only meaningful while msg_valid is high.
- frame_done  out  1  pulse: checksum correct.
- frame_error  out  1  pulse: frame aborted.
- error_code  out  2  01 unknown type, 10 checksum mismatch, 11 timeout. Held until the next frame_error.
- busy  out  1  high in every state except HUNT.

## Operation
- States:
  - HUNT: waits for byte 0 of SYNC_PATTERN; on a match, goes to SYNC (or to TYPE if SYNC_LEN==1).
  - SYNC: compares each byte to sync byte k.
    - All bytes matched: goes to TYPE.
    - Mismatch, and the byte equals sync byte 0: k restarts at 1.
    - Otherwise: goes to HUNT. No frame_error is raised.
  - TYPE: compares the byte to all TYPE_CODES; the lowest matching index wins.
    - Match: latches msg_type, loads remaining = PAYLOAD_LENS[i], loads csum = type byte, goes to PAYLOAD.
    - No match: raises frame_error with code 01, goes to HUNT.
  - PAYLOAD: each byte drives msg_out/msg_valid, csum ^= byte, remaining decrements. The byte seen when remaining==1 is the last; the FSM then goes to CHECK.
  - CHECK: compares the byte to csum.
    - Equal: frame_done.
    - Not equal: frame_error with code 10.
    - Either way, goes to HUNT.
- Payload bytes are forwarded before the checksum is known. Downstream discards the frame on frame_error.
- Timeout: the idle counter clears on every strobe and on entry to HUNT. When busy and the counter reaches TIMEOUT_CYCLES, raise frame_error with code 11 and go to HUNT.
- msg_first is high on the first payload byte. msg_last is high when remaining==1. With a length of 1, both are high on the same byte.

## Timing
- Reset values:
  - State is HUNT.
  - msg_out, msg_type, msg_valid, msg_first, msg_last, frame_done, frame_error, error_code and busy are all 0.
  - The counters are 0.
- Latency: every output pulse is registered and occurs one cycle after the rx_data_ready strobe that causes it.
- Back-to-back strobes (every cycle) must be accepted without loss.
- A strobe in the same cycle the timeout would fire: the strobe wins and is processed normally.
- The idle counter saturates and does not wrap.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. No error pulse is produced. The partial frame is lost.
- frame_done and frame_error are mutually exclusive and never coincide with msg_valid.
- A new frame's sync may begin in the cycle immediately after CHECK.

## Structure
- Shared package serial_frame_pkg holds:
  - the state encoding (HUNT, SYNC, TYPE, PAYLOAD, CHECK);
  - the error-code constants ERR_NONE, ERR_TYPE, ERR_CSUM, ERR_TIMEOUT;
  - the 16-bit length width constant.
- Sub-module serial_frame_timeout: saturating idle counter.
  - Inputs: clk, reset, clear, enable.
  - Output: expired.
  - Generated away when TIMEOUT_CYCLES==0 (expired tied to 0).

## Test plan
- Good frame: A5 5A 01 10 20 30 01.
  - 3 msg_valid pulses: 10 (first), 20, 30 (last).
  - msg_type=0.
  - frame_done one cycle after the 01 strobe.
- Overlapping sync: A5 A5 5A 02 01 02 03 04 05 03.
  - Frame is recognised, msg_type=1, 5 bytes forwarded, frame_done.
- Bad type: A5 5A 07 → frame_error with code 01. A following good frame decodes normally.
- Bad checksum: A5 5A 01 10 20 30 FF → 3 bytes forwarded, then frame_error with code 10, no frame_done.
- Timeout (TIMEOUT_CYCLES=50): A5 5A 01 10, then 50 idle cycles → frame_error with code 11, busy=0.
  - Repeat with the 4th byte strobed exactly on cycle 50: no error.
- Reset mid-PAYLOAD: all outputs are 0 the next cycle, with no error pulse. A following good frame decodes.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame decoder: FSM states, error codes, length width.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SYNC,
        TYPE,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TYPE    = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int LEN_W = 16;

endpackage

// File: rtl/serial_frame_timeout.sv
// Saturating idle counter; expired is high once TIMEOUT_CYCLES enabled, uncleared cycles have elapsed.
// Registered count, combinational compare; a TIMEOUT_CYCLES of 0 removes the counter entirely.
module serial_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    count <= '0;
                end else if (enable && (count != LIMIT)) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/serial_frame_decoder.sv
// Sync/type/payload/XOR-checksum frame decoder; all outputs registered, one cycle after the causing strobe.
// No backpressure: every rx_data_ready strobe is consumed, including back-to-back strobes.
module serial_frame_decoder
    import serial_frame_pkg::*;
#(
    parameter int                        SYNC_LEN       = 2,
    parameter logic [SYNC_LEN*8-1:0]     SYNC_PATTERN   = 16'hA55A,
    parameter int                        NUM_TYPES      = 2,
    parameter logic [NUM_TYPES*8-1:0]    TYPE_CODES     = {8'h02, 8'h01},
    parameter logic [NUM_TYPES*16-1:0]   PAYLOAD_LENS   = {16'd5, 16'd3},
    parameter int unsigned               TIMEOUT_CYCLES = 100000
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [7:0]                                         rx_data,
    input  logic                                               rx_data_ready,
    output logic [7:0]                                         msg_out,
    output logic [(NUM_TYPES > 1 ? $clog2(NUM_TYPES) : 1)-1:0] msg_type,
    output logic                                               msg_valid,
    output logic                                               msg_first,
    output logic                                               msg_last,
    output logic                                               frame_done,
    output logic                                               frame_error,
    output logic [1:0]                                         error_code,
    output logic                                               busy
);

    localparam int TW   = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
    localparam int SI_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

    state_t            state;
    logic [SI_W-1:0]   sync_idx;
    logic [LEN_W-1:0]  remaining;
    logic [7:0]        csum;
    logic              first_pend;
    logic              expired;

    logic              type_hit;
    logic [TW-1:0]     type_idx;
    logic [LEN_W-1:0]  type_len;

    // Byte k of the preamble; byte 0 is the first one on the wire.
    function automatic logic [7:0] sync_byte(input int k);
        return SYNC_PATTERN[8*(SYNC_LEN-1-k) +: 8];
    endfunction

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        type_hit = 1'b0;
        type_idx = '0;
        type_len = '0;
        for (int i = NUM_TYPES - 1; i >= 0; i--) begin
            if (rx_data == TYPE_CODES[8*i +: 8]) begin
                type_hit = 1'b1;
                type_idx = TW'(i);
                type_len = PAYLOAD_LENS[16*i +: 16];
            end
        end
    end

    serial_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_data_ready || (state == HUNT)),
        .enable (busy),
        .expired(expired)
    );

    assign busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            sync_idx    <= '0;
            remaining   <= '0;
            csum        <= '0;
            first_pend  <= 1'b0;
            msg_out     <= '0;
            msg_type    <= '0;
            msg_valid   <= 1'b0;
            msg_first   <= 1'b0;
            msg_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            error_code  <= ERR_NONE;
        end else begin
            msg_valid   <= 1'b0;
            msg_first   <= 1'b0;
            msg_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;

            if (rx_data_ready) begin
                case (state)
                    HUNT: begin
                        if (rx_data == sync_byte(0)) begin
                            if (SYNC_LEN == 1) begin
                                state <= TYPE;
                            end else begin
                                state    <= SYNC;
                                sync_idx <= SI_W'(1);
                            end
                        end
                    end
                    SYNC: begin
                        if (rx_data == sync_byte(int'(sync_idx))) begin
                            if (sync_idx == SI_W'(SYNC_LEN - 1)) begin
                                state <= TYPE;
                            end else begin
                                sync_idx <= sync_idx + 1'b1;
                            end
                        end else if (rx_data == sync_byte(0)) begin
                            sync_idx <= SI_W'(1);
                        end else begin
                            state <= HUNT;
                        end
                    end
                    TYPE: begin
                        if (type_hit) begin
                            msg_type   <= type_idx;
                            remaining  <= type_len;
                            csum       <= rx_data;
                            first_pend <= 1'b1;
                            state      <= PAYLOAD;
                        end else begin
                            frame_error <= 1'b1;
                            error_code  <= ERR_TYPE;
                            state       <= HUNT;
                        end
                    end
                    PAYLOAD: begin
                        msg_out    <= rx_data;
                        msg_valid  <= 1'b1;
                        msg_first  <= first_pend;
                        msg_last   <= (remaining == LEN_W'(1));
                        first_pend <= 1'b0;
                        csum       <= csum ^ rx_data;
                        remaining  <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (rx_data == csum) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            error_code  <= ERR_CSUM;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end else if (expired && (state != HUNT)) begin
                frame_error <= 1'b1;
                error_code  <= ERR_TIMEOUT;
                state       <= HUNT;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed bench for serial_frame_decoder with a stream-level reference model and per-cycle compare.
module tb_serial_frame_decoder;

    localparam int T  = 50;
    localparam int SL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ready = 1'b0;
    logic [7:0] msg_out;
    logic [0:0] msg_type;
    logic       msg_valid, msg_first, msg_last;
    logic       frame_done, frame_error, busy;
    logic [1:0] error_code;

    int checks = 0;
    int errors = 0;

    serial_frame_decoder #(
        .SYNC_LEN      (2),
        .SYNC_PATTERN  (16'hA55A),
        .NUM_TYPES     (2),
        .TYPE_CODES    (16'h0201),
        .PAYLOAD_LENS  (32'h0005_0003),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .msg_out      (msg_out),
        .msg_type     (msg_type),
        .msg_valid    (msg_valid),
        .msg_first    (msg_first),
        .msg_last     (msg_last),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the candidate frame are kept in a queue and
    // each new byte is judged by its position within that frame.
    logic [7:0] sync_b[2]    = '{8'hA5, 8'h5A};
    logic [7:0] type_code[2] = '{8'h01, 8'h02};
    int         type_len[2]  = '{3, 5};

    logic [7:0] frame[$];
    int         idle = 0;
    int         cur_len = 0;
    bit         model_ran = 1'b0;
    logic [7:0] e_out = 8'h00;
    logic [0:0] e_type = 1'b0;
    logic       e_valid = 1'b0, e_first = 1'b0, e_last = 1'b0;
    logic       e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
    logic [1:0] e_code = 2'b00;

    task automatic model_step();
        int n;
        int hit;
        logic [7:0] cs;
        e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0;
        e_done  = 1'b0; e_err   = 1'b0;
        if (reset) begin
            frame.delete();
            idle = 0; e_out = 8'h00; e_type = 1'b0; e_code = 2'b00;
        end else if (rx_data_ready) begin
            idle = 0;
            frame.push_back(rx_data);
            n = frame.size();
            if (n <= SL) begin
                if (rx_data != sync_b[n-1]) begin
                    frame.delete();
                    if (rx_data == sync_b[0]) frame.push_back(rx_data);
                end
            end else if (n == SL + 1) begin
                hit = -1;
                for (int i = 1; i >= 0; i--) if (rx_data == type_code[i]) hit = i;
                if (hit < 0) begin
                    e_err = 1'b1; e_code = 2'b01; frame.delete();
                end else begin
                    e_type = (hit == 1); cur_len = type_len[hit];
                end
            end else if (n <= SL + 1 + cur_len) begin
                e_valid = 1'b1; e_out = rx_data;
                e_first = (n == SL + 2);
                e_last  = (n == SL + 1 + cur_len);
            end else begin
                cs = 8'h00;
                for (int i = SL; i < n - 1; i++) cs = cs ^ frame[i];
                if (cs == rx_data) e_done = 1'b1;
                else begin e_err = 1'b1; e_code = 2'b10; end
                frame.delete();
            end
        end else if (frame.size() > 0) begin
            if (idle == T) begin
                e_err = 1'b1; e_code = 2'b11; frame.delete(); idle = 0;
            end else begin
                idle++;
            end
        end
        e_busy = (frame.size() > 0);
    endtask

    always @(posedge clk) begin
        model_step();
        model_ran = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ran) begin
            checks++;
            if ({msg_out, msg_type, msg_valid, msg_first, msg_last, frame_done, frame_error, error_code, busy} !==
                {e_out, e_type, e_valid, e_first, e_last, e_done, e_err, e_code, e_busy}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got out=%h type=%0d v=%b f=%b l=%b done=%b err=%b code=%b busy=%b required out=%h type=%0d v=%b f=%b l=%b done=%b err=%b code=%b busy=%b",
                         $time, msg_out, msg_type, msg_valid, msg_first, msg_last, frame_done, frame_error, error_code, busy,
                         e_out, e_type, e_valid, e_first, e_last, e_done, e_err, e_code, e_busy);
            end
        end
    end

    // Observation of DUT pulses for the hand-computed literal checks.
    logic [7:0] got[$];
    int         done_cnt = 0, err_cnt = 0;
    logic [7:0] first_b = 8'h00, last_b = 8'h00;

    always @(negedge clk) begin
        if (msg_valid === 1'b1) begin
            got.push_back(msg_out);
            if (msg_first === 1'b1) first_b = msg_out;
            if (msg_last === 1'b1) last_b = msg_out;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    task automatic clear_mon();
        got.delete(); done_cnt = 0; err_cnt = 0; first_b = 8'h00; last_b = 8'h00;
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [7:0] d);
        @(posedge clk);
        #1;
        reset = r; rx_data_ready = s; rx_data = d;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] q[$];

    task automatic send_q();
        foreach (q[i]) cyc(1'b0, 1'b1, q[i]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("reset_outputs", int'({msg_out, msg_type, msg_valid, msg_first, msg_last,
                                   frame_done, frame_error, error_code, busy}), 0);
        cyc(1'b0, 1'b0, 8'h00);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01, 8'h10, 8'h20, 8'h30, 8'h01};
        send_q(); idle_cycles(3);
        lit("good_count", got.size(), 3);
        lit("good_mid", (got.size() > 1) ? int'(got[1]) : -1, 'h20);
        lit("good_first", int'(first_b), 'h10);
        lit("good_last", int'(last_b), 'h30);
        lit("good_type", int'(msg_type), 0);
        lit("good_done", done_cnt, 1);
        lit("good_err", err_cnt, 0);

        clear_mon();
        q = '{8'hA5, 8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03};
        send_q(); idle_cycles(3);
        lit("overlap_count", got.size(), 5);
        lit("overlap_type", int'(msg_type), 1);
        lit("overlap_last", int'(last_b), 'h05);
        lit("overlap_done", done_cnt, 1);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h07, 8'hA5, 8'h5A, 8'h01, 8'h10, 8'h20, 8'h30, 8'h01};
        send_q(); idle_cycles(3);
        lit("badtype_err", err_cnt, 1);
        lit("badtype_code", int'(error_code), 1);
        lit("badtype_next_done", done_cnt, 1);
        lit("badtype_next_count", got.size(), 3);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01, 8'h10, 8'h20, 8'h30, 8'hFF};
        send_q(); idle_cycles(3);
        lit("badcsum_count", got.size(), 3);
        lit("badcsum_err", err_cnt, 1);
        lit("badcsum_code", int'(error_code), 2);
        lit("badcsum_done", done_cnt, 0);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01, 8'h10, 8'h20, 8'h30, 8'h01,
              8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03};
        send_q(); idle_cycles(3);
        lit("b2b_done", done_cnt, 2);
        lit("b2b_count", got.size(), 8);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01, 8'h10};
        send_q(); idle_cycles(55);
        lit("timeout_err", err_cnt, 1);
        lit("timeout_code", int'(error_code), 3);
        lit("timeout_busy", int'(busy), 0);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01};
        send_q(); idle_cycles(T);
        q = '{8'h10, 8'h20, 8'h30, 8'h01};
        send_q(); idle_cycles(3);
        lit("edge_strobe_err", err_cnt, 0);
        lit("edge_strobe_done", done_cnt, 1);

        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02};
        send_q();
        cyc(1'b1, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        lit("rst_mid_outputs", int'({msg_out, msg_type, msg_valid, msg_first, msg_last,
                                     frame_done, frame_error, error_code, busy}), 0);
        lit("rst_mid_err", err_cnt, 0);
        cyc(1'b0, 1'b0, 8'h00);
        clear_mon();
        q = '{8'hA5, 8'h5A, 8'h01, 8'h10, 8'h20, 8'h30, 8'h01};
        send_q(); idle_cycles(3);
        lit("after_rst_done", done_cnt, 1);
        lit("after_rst_count", got.size(), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
